spi_master: RTL and testbench

Transmit-only SPI master, mode 0 (CPOL=0, CPHA=0), MSB first. On a rising edge of req it latches an 8-bit word and drives it on sdo with a generated sclk, framed by active-low ss. It pulses snt when the frame completes. It sits between control logic (e.g. a display or sensor command sequencer) and an external SPI slave.

---
 rtl/spi_master_pkg.sv | 18 +
 rtl/spi_master_if.sv | 35 +++
 rtl/spi_master_clk_gen.sv | 59 +++++
 rtl/spi_master.sv | 117 +++++++++++
 tb/tb_spi_master.sv | 323 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_master_pkg.sv
// Shared types and defaults for the transmit-only SPI master (mode 0, MSB first).
package spi_master_pkg;

  localparam int DATA_W_DEF      = 8;
  localparam int HALF_PERIOD_DEF = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Counter width able to hold 0..n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spi_master_if.sv
// Request/data handshake plus the SPI pins of the SPI master.
// The master modport is the SPI master itself; the slave modport is the
// control logic that issues requests and watches the pins.
interface spi_master_if
  import spi_master_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) ();

  logic              req;
  logic [DATA_W-1:0] dat;
  logic              sclk;
  logic              ss;
  logic              sdo;
  logic              snt;

  modport master (
    input  req,
    input  dat,
    output sclk,
    output ss,
    output sdo,
    output snt
  );

  modport slave (
    output req,
    output dat,
    input  sclk,
    input  ss,
    input  sdo,
    input  snt
  );

endinterface

// File: rtl/spi_master_clk_gen.sv
// SPI serial clock generator: counts HALF_PERIOD clk cycles per sclk half-period
// while enabled and flags the cycle on which sclk is about to rise or fall.
// When disabled the counter is parked at zero and sclk is held low, so the
// first half-period of a frame always starts cleanly.
module spi_master_clk_gen
  import spi_master_pkg::*;
#(
  parameter int HALF_PERIOD = HALF_PERIOD_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  output logic sclk_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int              HC_W    = cnt_width(HALF_PERIOD);
  localparam logic [HC_W-1:0] HC_LAST = HC_W'(HALF_PERIOD - 1);

  logic [HC_W-1:0] hcnt_q, hcnt_d;
  logic            sclk_q, sclk_d;
  logic            tick_s;

  // Half-period counting and sclk toggle decision.
  always_comb begin
    tick_s = 1'b0;
    hcnt_d = hcnt_q;
    sclk_d = sclk_q;
    if (en_i) begin
      if (hcnt_q == HC_LAST) begin
        tick_s = 1'b1;
        hcnt_d = {HC_W{1'b0}};
        sclk_d = ~sclk_q;
      end else begin
        hcnt_d = hcnt_q + HC_W'(1'b1);
      end
    end else begin
      hcnt_d = {HC_W{1'b0}};
      sclk_d = 1'b0;
    end
  end

  // Counter and sclk registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt_q <= {HC_W{1'b0}};
      sclk_q <= 1'b0;
    end else begin
      hcnt_q <= hcnt_d;
      sclk_q <= sclk_d;
    end
  end

  assign sclk_o = sclk_q;
  assign rise_o = tick_s & ~sclk_q;
  assign fall_o = tick_s & sclk_q;

endmodule

// File: rtl/spi_master.sv
// Transmit-only SPI master, mode 0, MSB first. A rising edge of req while idle
// latches dat and sends it on sdo under ss low; snt pulses for one cycle when
// the last bit has been clocked out. sdo is the MSB of the shift register, so
// every output pin comes straight from a flop.
module spi_master
  import spi_master_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int HALF_PERIOD = HALF_PERIOD_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  spi_master_if.master bus
);

  localparam int              BC_W    = cnt_width(DATA_W);
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(DATA_W - 1);

  state_e            state_q, state_d;
  logic              req_q;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [BC_W-1:0]   bcnt_q, bcnt_d;
  logic              ss_q, ss_d;
  logic              snt_q, snt_d;

  logic start_s;
  logic sclk_s;
  logic rise_s;
  logic fall_s;

  assign start_s = bus.req & ~req_q & (state_q == IDLE);

  spi_master_clk_gen #(
    .HALF_PERIOD (HALF_PERIOD)
  ) u_clk_gen (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   (state_q == SHIFT),
    .sclk_o (sclk_s),
    .rise_o (rise_s),
    .fall_o (fall_s)
  );

  // Frame sequencing: accept, shift on falling sclk, close the frame.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    bcnt_d  = bcnt_q;
    ss_d    = ss_q;
    snt_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_s) begin
          state_d = SHIFT;
          shreg_d = bus.dat;
          bcnt_d  = {BC_W{1'b0}};
          ss_d    = 1'b0;
        end else begin
          ss_d    = 1'b1;
        end
      end
      SHIFT: begin
        if (fall_s) begin
          if (bcnt_q == BC_LAST) begin
            state_d = DONE;
            shreg_d = {DATA_W{1'b0}};
            bcnt_d  = {BC_W{1'b0}};
            ss_d    = 1'b1;
            snt_d   = 1'b1;
          end else begin
            bcnt_d  = bcnt_q + BC_W'(1'b1);
            shreg_d = {shreg_q[DATA_W-2:0], 1'b0};
          end
        end else if (rise_s) begin
          // The slave samples on this edge, so the data bit must not move.
          shreg_d = shreg_q;
        end else begin
          state_d = SHIFT;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        shreg_d = {DATA_W{1'b0}};
        bcnt_d  = {BC_W{1'b0}};
        ss_d    = 1'b1;
      end
    endcase
  end

  // State, request history, shift register and output flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      shreg_q <= {DATA_W{1'b0}};
      bcnt_q  <= {BC_W{1'b0}};
      ss_q    <= 1'b1;
      snt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= bus.req;
      shreg_q <= shreg_d;
      bcnt_q  <= bcnt_d;
      ss_q    <= ss_d;
      snt_q   <= snt_d;
    end
  end

  assign bus.sclk = sclk_s;
  assign bus.ss   = ss_q;
  assign bus.sdo  = shreg_q[DATA_W-1];
  assign bus.snt  = snt_q;

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: one instance at HALF_PERIOD=1 and one at HALF_PERIOD=4
// run side by side. A frame-level model (start cycle + word) predicts every
// pin on every cycle; a pin monitor reassembles bytes, snt counts, ss-low
// length and sclk period for hand-computed directed checks.
module tb_spi_master;

  localparam int W    = 8;
  localparam int NDUT = 2;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         req_s  [NDUT];
  logic [W-1:0] dat_s  [NDUT];
  logic         sclk_s [NDUT];
  logic         ss_s   [NDUT];
  logic         sdo_s  [NDUT];
  logic         snt_s  [NDUT];

  int checks = 0;
  int errors = 0;
  int ncyc   = 0;

  always #5 clk = ~clk;

  function automatic int hp_of(input int g);
    return (g == 0) ? 1 : 4;
  endfunction

  function automatic int frame_of(input int g);
    return 2 * hp_of(g) * W;
  endfunction

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam int HP = (g == 0) ? 1 : 4;
    spi_master_if #(.DATA_W(W)) bus ();
    assign bus.req   = req_s[g];
    assign bus.dat   = dat_s[g];
    assign sclk_s[g] = bus.sclk;
    assign ss_s[g]   = bus.ss;
    assign sdo_s[g]  = bus.sdo;
    assign snt_s[g]  = bus.snt;
    spi_master #(.DATA_W(W), .HALF_PERIOD(HP)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
    );
  end

  task automatic cmp(input int g, input string nm, input logic got, input logic want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL g%0d %s at cycle %0d: got %b, want %b", g, nm, ncyc, got, want);
    end
  endtask

  task automatic chk(input string nm, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", nm, got, got, want, want);
    end
  endtask

  // Cycle counter for messages and period measurement.
  always @(posedge clk) ncyc <= ncyc + 1;

  // Frame-level model: a frame is (start edge, word); t = clk edges since start.
  bit           act_m  [NDUT];
  int           t_m    [NDUT];
  logic [W-1:0] w_m    [NDUT];
  logic         prev_m [NDUT];
  int           done_m [NDUT];

  // Model: accept a req rising edge only when no frame is in progress.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int g = 0; g < NDUT; g++) begin
        act_m[g]  <= 1'b0;
        t_m[g]    <= 0;
        prev_m[g] <= 1'b0;
      end
    end else begin
      for (int g = 0; g < NDUT; g++) begin
        prev_m[g] <= req_s[g];
        if (act_m[g]) begin
          t_m[g] <= t_m[g] + 1;
          if (t_m[g] == frame_of(g) - 1) done_m[g] <= done_m[g] + 1;
          if (t_m[g] == frame_of(g)) act_m[g] <= 1'b0;
        end else if (req_s[g] && !prev_m[g]) begin
          act_m[g] <= 1'b1;
          t_m[g]   <= 0;
          w_m[g]   <= dat_s[g];
        end
      end
    end
  end

  // Compare every pin of both instances against the model each cycle.
  always @(negedge clk) begin
    logic e_ss, e_sclk, e_sdo, e_snt;
    for (int g = 0; g < NDUT; g++) begin
      if (act_m[g] && t_m[g] < frame_of(g)) begin
        e_ss   = 1'b0;
        e_sclk = ((t_m[g] / hp_of(g)) % 2) == 1;
        e_sdo  = w_m[g][W - 1 - t_m[g] / (2 * hp_of(g))];
        e_snt  = 1'b0;
      end else if (act_m[g] && t_m[g] == frame_of(g)) begin
        e_ss = 1'b1; e_sclk = 1'b0; e_sdo = 1'b0; e_snt = 1'b1;
      end else begin
        e_ss = 1'b1; e_sclk = 1'b0; e_sdo = 1'b0; e_snt = 1'b0;
      end
      cmp(g, "ss", ss_s[g], e_ss);
      cmp(g, "sclk", sclk_s[g], e_sclk);
      cmp(g, "sdo", sdo_s[g], e_sdo);
      cmp(g, "snt", snt_s[g], e_snt);
    end
  end

  // Pin monitor: bytes sampled on sclk rises, snt count, ss-low run, sclk period.
  logic [W-1:0] cap_m     [NDUT];
  int           nbits_m   [NDUT];
  logic         psclk_m   [NDUT];
  int           run_m     [NDUT];
  logic [W-1:0] last_byte [NDUT];
  int           snt_cnt   [NDUT];
  int           last_low  [NDUT];
  int           last_per  [NDUT];
  int           last_rise [NDUT];

  // Monitor update.
  always @(negedge clk) begin
    for (int g = 0; g < NDUT; g++) begin
      if (!rst_n) begin
        cap_m[g]   <= '0;
        nbits_m[g] <= 0;
        psclk_m[g] <= 1'b0;
        run_m[g]   <= 0;
      end else begin
        psclk_m[g] <= sclk_s[g];
        if (sclk_s[g] && !psclk_m[g]) begin
          cap_m[g]     <= {cap_m[g][W-2:0], sdo_s[g]};
          nbits_m[g]   <= nbits_m[g] + 1;
          last_rise[g] <= ncyc;
          if (nbits_m[g] != 0) last_per[g] <= ncyc - last_rise[g];
        end
        if (snt_s[g]) begin
          snt_cnt[g]   <= snt_cnt[g] + 1;
          last_byte[g] <= cap_m[g];
          nbits_m[g]   <= 0;
        end
        if (!ss_s[g]) begin
          run_m[g] <= run_m[g] + 1;
        end else if (run_m[g] != 0) begin
          last_low[g] <= run_m[g];
          run_m[g]    <= 0;
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_all(input logic r, input logic [W-1:0] d);
    for (int g = 0; g < NDUT; g++) begin
      req_s[g] = r;
      dat_s[g] = d;
    end
  endtask

  task automatic wait_done(input string nm, input int b0, input int b1);
    int n = 0;
    while ((snt_cnt[0] == b0 || snt_cnt[1] == b1) && n < 1000) begin
      @(posedge clk);
      n++;
    end
    #1;
    checks++;
    if (n >= 1000) begin
      errors++;
      $display("FAIL %s snt wait: counts %0d/%0d, want above %0d/%0d", nm,
               snt_cnt[0], snt_cnt[1], b0, b1);
    end
  endtask

  task automatic check_frame(input string nm, input logic [W-1:0] want, input int b0, input int b1);
    chk({nm, " g0 byte"}, int'(last_byte[0]), int'(want));
    chk({nm, " g1 byte"}, int'(last_byte[1]), int'(want));
    chk({nm, " g0 snt count"}, snt_cnt[0] - b0, 1);
    chk({nm, " g1 snt count"}, snt_cnt[1] - b1, 1);
    chk({nm, " g0 ss low cycles"}, last_low[0], 16);
    chk({nm, " g1 ss low cycles"}, last_low[1], 64);
    chk({nm, " g0 sclk period"}, last_per[0], 2);
    chk({nm, " g1 sclk period"}, last_per[1], 8);
    for (int g = 0; g < NDUT; g++) begin
      chk({nm, " idle sclk"}, int'(sclk_s[g]), 0);
      chk({nm, " idle ss"}, int'(ss_s[g]), 1);
    end
  endtask

  initial begin
    int b0, b1, n;
    drive_all(1'b0, 8'h00);
    rst_n = 1'b0;
    step(3);
    rst_n = 1'b1;
    @(negedge clk);
    for (int g = 0; g < NDUT; g++) begin
      chk("reset ss", int'(ss_s[g]), 1);
      chk("reset sclk", int'(sclk_s[g]), 0);
      chk("reset sdo", int'(sdo_s[g]), 0);
      chk("reset snt", int'(snt_s[g]), 0);
    end
    step(1);

    // Basic frame 0x0C with req held well past the end of the frame.
    b0 = snt_cnt[0]; b1 = snt_cnt[1];
    drive_all(1'b1, 8'h0C);
    wait_done("f0C", b0, b1);
    step(3);
    check_frame("f0C", 8'h0C, b0, b1);

    // One low cycle, then 0x01; level-high req must not start a third frame.
    drive_all(1'b0, 8'h0C);
    step(1);
    b0 = snt_cnt[0]; b1 = snt_cnt[1];
    drive_all(1'b1, 8'h01);
    wait_done("f01", b0, b1);
    step(100);
    check_frame("f01", 8'h01, b0, b1);

    // dat changes mid-frame must not reach the wire.
    drive_all(1'b0, 8'h00);
    step(1);
    b0 = snt_cnt[0]; b1 = snt_cnt[1];
    drive_all(1'b1, 8'h0C);
    step(5);
    drive_all(1'b1, 8'hFF);
    wait_done("datchg", b0, b1);
    step(2);
    check_frame("datchg", 8'h0C, b0, b1);

    // A fresh req edge during SHIFT is neither honoured nor queued.
    drive_all(1'b0, 8'h00);
    step(1);
    b0 = snt_cnt[0]; b1 = snt_cnt[1];
    drive_all(1'b1, 8'h5A);
    step(4);
    drive_all(1'b0, 8'h5A);
    step(1);
    drive_all(1'b1, 8'h5A);
    wait_done("reqtog", b0, b1);
    drive_all(1'b0, 8'h00);
    step(100);
    check_frame("reqtog", 8'h5A, b0, b1);

    // Reset at bit 4 of the fast instance aborts both frames at once.
    b0 = snt_cnt[0]; b1 = snt_cnt[1];
    drive_all(1'b1, 8'h3C);
    n = 0;
    while (nbits_m[0] != 4 && n < 200) begin
      @(posedge clk);
      n++;
    end
    chk("abort reached bit 4", nbits_m[0], 4);
    #1 rst_n = 1'b0;
    #1;
    for (int g = 0; g < NDUT; g++) begin
      chk("abort ss", int'(ss_s[g]), 1);
      chk("abort sclk", int'(sclk_s[g]), 0);
      chk("abort sdo", int'(sdo_s[g]), 0);
      chk("abort snt", int'(snt_s[g]), 0);
    end
    drive_all(1'b0, 8'h00);
    step(2);
    rst_n = 1'b1;
    step(3);
    chk("abort g0 no snt", snt_cnt[0] - b0, 0);
    chk("abort g1 no snt", snt_cnt[1] - b1, 0);
    b0 = snt_cnt[0]; b1 = snt_cnt[1];
    drive_all(1'b1, 8'hC3);
    wait_done("afterrst", b0, b1);
    step(2);
    check_frame("afterrst", 8'hC3, b0, b1);

    // 0xA5: alternating pattern, sclk period checked on both instances.
    drive_all(1'b0, 8'h00);
    step(1);
    b0 = snt_cnt[0]; b1 = snt_cnt[1];
    drive_all(1'b1, 8'hA5);
    wait_done("fA5", b0, b1);
    step(2);
    check_frame("fA5", 8'hA5, b0, b1);

    // Random requests, data and occasional resets, judged by the model.
    drive_all(1'b0, 8'h00);
    step(2);
    for (int i = 0; i < 4000; i++) begin
      for (int g = 0; g < NDUT; g++) begin
        if ($urandom_range(0, 7) == 0) req_s[g] = ~req_s[g];
        dat_s[g] = W'($urandom);
      end
      if ($urandom_range(0, 599) == 0) begin
        rst_n = 1'b0;
        step(1 + $urandom_range(0, 2));
        rst_n = 1'b1;
      end
      step(1);
    end
    drive_all(1'b0, 8'h00);
    step(150);
    for (int g = 0; g < NDUT; g++) begin
      chk("total frames vs model", snt_cnt[g], done_m[g]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
